// File: rtl/fsm_seq_gen_pkg.sv
// Shared types and width helpers for the serial sequence generator.
package fsm_seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int unsigned len_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    // Never narrower than one bit, so GAP_CYCLES=0 still yields a legal vector.
    function automatic int unsigned gap_cnt_width(input int unsigned gap_cycles);
        return (gap_cycles > 0) ? $clog2(gap_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/fsm_seq_gen_if.sv
// Control and serial-stream bundle between a stimulus master and the generator.
interface fsm_seq_gen_if
    import fsm_seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = len_width(WIDTH),
    parameter int unsigned RPT_W = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [RPT_W-1:0] rpt;
    logic             X;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, len, rpt,
        input  X, x_valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, len, rpt,
        output X, x_valid, busy, done
    );
endinterface

// File: rtl/fsm_seq_gen_piso_shift.sv
// Parallel-in serial-out register; a load left-aligns the active field so its MSB is the output flop.
module piso_shift
    import fsm_seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = len_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [LEN_W-1:0] idx_i,
    output logic             msb_o
);
    logic [WIDTH-1:0] sr_q;
    logic [LEN_W-1:0] align;

    // idx_i is the field length; bits above it fall off the top.
    assign align = LEN_W'(WIDTH) - idx_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= din_i << align;
        end else if (shift_i) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb_o = sr_q[WIDTH-1];
endmodule

// File: rtl/fsm_seq_gen.sv
// Serial sequence generator: shifts a captured pattern out MSB-first with optional gapped repeats.
module fsm_seq_gen
    import fsm_seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LEN_W      = len_width(WIDTH),
    parameter int unsigned RPT_W      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    fsm_seq_gen_if.slave  bus
);
    localparam int unsigned GW = gap_cnt_width(GAP_CYCLES);
    localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
    localparam logic [GW-1:0]    GAP_ONE  = GW'(1);

    state_e           state_q;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [RPT_W-1:0] rpt_q;
    logic [LEN_W-1:0] bit_cnt_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             x_valid_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] len_clamp;
    logic             accept;
    logic             last_bit;
    logic             gap_end;
    logic             piso_load;
    logic             piso_shift;
    logic [WIDTH-1:0] piso_din;
    logic [LEN_W-1:0] piso_idx;
    logic             x_bit;

    assign len_clamp = (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
    assign accept    = (state_q == IDLE) && bus.start && !bus.abort;
    assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == '0);
    assign gap_end   = (state_q == GAP) && (gap_cnt_q == '0);

    // Shifter steering mirrors the FSM transitions; loading zeros is how X is forced low.
    always_comb begin
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_din   = '0;
        piso_idx   = len_q;
        if (bus.abort) begin
            piso_load = 1'b1;
        end else if (accept) begin
            piso_load = 1'b1;
            piso_din  = bus.pattern;
            piso_idx  = len_clamp;
        end else if ((state_q == SHIFT) && (bit_cnt_q != '0)) begin
            piso_shift = 1'b1;
        end else if (last_bit) begin
            piso_load = 1'b1;
            if ((rpt_q != '0) && (GAP_CYCLES == 0)) begin
                piso_din = pat_q;
            end
        end else if (gap_end) begin
            piso_load = 1'b1;
            piso_din  = pat_q;
        end
    end

    piso_shift #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk     (clk),
        .rst_n   (reset_n),
        .load_i  (piso_load),
        .shift_i (piso_shift),
        .din_i   (piso_din),
        .idx_i   (piso_idx),
        .msb_o   (x_bit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            rpt_q     <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q   <= IDLE;
                x_valid_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            pat_q <= bus.pattern;
                            len_q <= len_clamp;
                            rpt_q <= bus.rpt;
                            if (len_clamp == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= SHIFT;
                                bit_cnt_q <= len_clamp - LEN_ONE;
                                x_valid_q <= 1'b1;
                                busy_q    <= 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt_q != '0) begin
                            bit_cnt_q <= bit_cnt_q - LEN_ONE;
                        end else if (rpt_q != '0) begin
                            rpt_q <= rpt_q - RPT_ONE;
                            if (GAP_CYCLES > 0) begin
                                state_q   <= GAP;
                                gap_cnt_q <= GAP_LOAD;
                                x_valid_q <= 1'b0;
                            end else begin
                                bit_cnt_q <= len_q - LEN_ONE;
                            end
                        end else begin
                            state_q   <= DONE;
                            x_valid_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt_q != '0) begin
                            gap_cnt_q <= gap_cnt_q - GAP_ONE;
                        end else begin
                            state_q   <= SHIFT;
                            bit_cnt_q <= len_q - LEN_ONE;
                            x_valid_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.X       = x_bit;
    assign bus.x_valid = x_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_fsm_seq_gen.sv
// Randomised self-checking bench: one generator with a one-cycle gap, one back-to-back.
module tb_fsm_seq_gen;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    always #5 clk = ~clk;

    fsm_seq_gen_if #(.WIDTH(8), .LEN_W(4), .RPT_W(4)) bus0 ();
    fsm_seq_gen_if #(.WIDTH(8), .LEN_W(4), .RPT_W(4)) bus1 ();

    fsm_seq_gen #(.WIDTH(8), .LEN_W(4), .RPT_W(4), .GAP_CYCLES(1)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    fsm_seq_gen #(.WIDTH(8), .LEN_W(4), .RPT_W(4), .GAP_CYCLES(0)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {X, x_valid, busy, done}
    function automatic logic [3:0] sample(input int sel);
        if (sel == 0) return {bus0.X, bus0.x_valid, bus0.busy, bus0.done};
        return {bus1.X, bus1.x_valid, bus1.busy, bus1.done};
    endfunction

    task automatic drive(input int sel, input logic st, input logic ab,
                         input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        if (sel == 0) begin
            bus0.start = st; bus0.abort = ab; bus0.pattern = p; bus0.len = l; bus0.rpt = r;
        end else begin
            bus1.start = st; bus1.abort = ab; bus1.pattern = p; bus1.len = l; bus1.rpt = r;
        end
    endtask

    task automatic set_ctl(input int sel, input logic st, input logic ab);
        if (sel == 0) begin bus0.start = st; bus0.abort = ab; end
        else          begin bus1.start = st; bus1.abort = ab; end
    endtask

    // Expected per-cycle outputs, starting with the cycle after the accepting edge.
    task automatic build_expect(input int gap, input logic [7:0] p, input int l, input int r,
                                output logic [3:0] q[$]);
        int lc;
        q.delete();
        lc = (l > 8) ? 8 : l;
        if (lc > 0) begin
            for (int rep = 0; rep <= r; rep++) begin
                for (int b = lc - 1; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0});
                if (rep < r) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
            end
        end
        q.push_back(4'b0001);
        q.push_back(4'b0000);
    endtask

    task automatic run_seq(input int sel, input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] r, input int abort_at, input bit hold, input string name);
        logic [3:0] q[$];
        build_expect((sel == 0) ? 1 : 0, p, int'(l), int'(r), q);
        if (abort_at >= 0 && abort_at < q.size()) begin
            while (q.size() > abort_at + 1) void'(q.pop_back());
            q.push_back(4'b0000);
            q.push_back(4'b0000);
        end
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, p, l, r);
        @(posedge clk);
        #1;
        drive(sel, hold, 1'b0, 8'($urandom), 4'($urandom), 4'($urandom));
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            check_eq($sformatf("%s d%0d k%0d", name, sel, k), 32'(sample(sel)), 32'(q[k]));
            set_ctl(sel, hold && (k < q.size() - 1), (k == abort_at));
        end
        set_ctl(sel, 1'b0, 1'b0);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset d0", 32'(sample(0)), 32'h0);
        check_eq("reset d1", 32'(sample(1)), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_seq(0, 8'b0000_0110, 4'd3,  4'd0, -1, 1'b0, "single");
        run_seq(0, 8'b0000_0101, 4'd3,  4'd2, -1, 1'b0, "rptgap");
        run_seq(1, 8'b0000_0010, 4'd2,  4'd1, -1, 1'b0, "b2b");
        run_seq(0, 8'hA5,        4'd0,  4'd2, -1, 1'b0, "len0");
        run_seq(0, 8'b1011_0010, 4'd12, 4'd0, -1, 1'b0, "clamp");
        run_seq(0, 8'b0000_0101, 4'd3,  4'd0, -1, 1'b1, "hold");
        run_seq(1, 8'h00,        4'd0,  4'd0, -1, 1'b1, "hold0");
        run_seq(0, 8'b0001_0110, 4'd5,  4'd1,  1, 1'b0, "abort");

        // Asynchronous reset landing in the middle of a gap cycle.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'b0000_0101, 4'd3, 4'd2);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 8'hFF, 4'd7, 4'd0);
        repeat (3) @(posedge clk);
        #2;
        check_eq("in gap", 32'(sample(0)), 32'h2);
        reset_n = 1'b0;
        #1;
        check_eq("async rst d0", 32'(sample(0)), 32'h0);
        check_eq("async rst d1", 32'(sample(1)), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_seq(0, 8'b0000_0110, 4'd3, 4'd1, -1, 1'b0, "post rst");

        for (int i = 0; i < 60; i++) begin
            int sel;
            int ab;
            bit hold;
            sel  = (i % 3 == 2) ? 1 : 0;
            hold = ($urandom_range(0, 4) == 0);
            ab   = (!hold && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_seq(sel, 8'($urandom), 4'($urandom_range(0, 12)), 4'($urandom_range(0, 3)),
                    ab, hold, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
